fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch-stage sequencer. Owns the architectural fetch PC, drives the instruction-bus request handshake, and arbitrates redirect sources (interrupt, trap return, CSR flush, branch/jump). It kills or drains in-flight fetches on a redirect and presents one instruction at a time to decode through a valid/ready handshake.

Parameters:
RESET_PC, 64'h8000_0000, first fetch address after reset
CNT_W, 32, width of the killed-fetch performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
interrupt  in  1  trap-entry redirect request
interrupt_pc  in  64  trap vector target
leave  in  1  trap-return (mret) redirect request
leave_pc  in  64  trap-return target
csrwrite  in  1  CSR-write pipeline flush request
csrwrite_pc  in  64  flush restart target
jump  in  1  branch/jump taken
j_addr  in  64  branch/jump target
ireq_valid  out  1  instruction-bus request valid
ireq_addr  out  64  request address
iresp_ok  in  1  request completed this cycle; iresp_data valid
iresp_data  in  32  fetched instruction
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts this cycle
if_pc  out  64  PC of presented instruction
if_instr  out  32  presented instruction
kill_cnt  out  CNT_W  count of fetches discarded due to redirect

Behaviour:
- Redirect target is a priority mux: interrupt > leave > csrwrite > jump. any_redir is the OR of all four. Only the winner's target is used.
- Registers: state, pc_q, instr_q, pend_pc, kill_cnt.
- States:
  - IDLE (reset state)
  - REQ (request outstanding)
  - HOLD (instruction held for decode)
  - DRAIN (request outstanding but stale; response will be discarded)
- Reset values: state=IDLE, pc_q=RESET_PC, instr_q=0, pend_pc=0, kill_cnt=0.
- Outputs during reset and in IDLE: ireq_valid=0, if_valid=0.
- IDLE:
  - always go to REQ next cycle.
  - Redirects in IDLE are ignored.
- REQ: ireq_valid=1, ireq_addr=pc_q. Address and valid stay stable until iresp_ok.
  - iresp_ok & !any_redir: instr_q<=iresp_data; go to HOLD.
  - iresp_ok & any_redir: discard data; pc_q<=target; kill_cnt++; stay in REQ. The new address appears next cycle.
  - !iresp_ok & any_redir: pend_pc<=target; go to DRAIN.
- DRAIN: ireq_valid=1, ireq_addr=pc_q (old address, held stable).
  - any_redir: pend_pc<=target (latest redirect wins).
  - iresp_ok: discard data; kill_cnt++; pc_q<=(any_redir ? target : pend_pc); go to REQ.
- HOLD: ireq_valid=0. if_valid = !any_redir (combinational kill). if_pc=pc_q, if_instr=instr_q.
  - any_redir: pc_q<=target; kill_cnt++; go to REQ. No transfer occurs even if if_ready=1.
  - if_ready & !any_redir: transfer; pc_q<=pc_q+4; go to REQ.
  - otherwise: hold all state.
- Latency:
  - First request is 1 cycle after reset release.
  - Instruction appears in the cycle after iresp_ok.
  - Minimum fetch period is 2 cycles (no prefetch).
- Arithmetic:
  - pc_q+4 wraps modulo 2^64.
  - kill_cnt saturates at all-ones.
  - Targets pass through unchecked; alignment faults are detected downstream.
- Reset mid-operation: immediate return to reset values. Any in-flight bus response is ignored, because the bus is reset on the same reset.

Decomposition:
- In common package: fetch_state_t enum (IDLE, REQ, HOLD, DRAIN); RESET_PC default constant. Reuse u1/u64/u32.
- One sub-module, redirect_arb: purely combinational priority mux producing any_redir and target. It is shared with future branch-prediction work.

Test Plan:
- Reset release, iresp_ok one cycle after each request with data 0x00000013, if_ready=1 → ireq_addr sequence 0x80000000, 0x80000004, 0x80000008; if_valid pulses every 2 cycles; kill_cnt=0.
- HOLD with if_ready=0 for 5 cycles → if_pc/if_instr stable; no new request; pc_q unchanged.
- jump=1, j_addr=0x80001000 in REQ while iresp_ok=0, then iresp_ok 3 cycles later → ireq_addr stays 0x80000000 until ok; data dropped; next request at 0x80001000; kill_cnt=1.
- Same cycle: interrupt (0x80000100), leave (0x80000200) and jump in HOLD with if_ready=1 → if_valid=0; next ireq_addr=0x80000100; no transfer.
- In DRAIN, jump to 0x80002000, then csrwrite to 0x80003000 two cycles later, then iresp_ok → next request at 0x80003000.
- Assert reset while in DRAIN → ireq_valid=0 immediately; after release, first request at RESET_PC; kill_cnt=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package fetch_ctrl_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    // Fetch FSM encoding, kept as plain constants so older tools can reuse it.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t IDLE  = 2'd0;  // reset state, nothing outstanding
    localparam fetch_state_t REQ   = 2'd1;  // request outstanding
    localparam fetch_state_t HOLD  = 2'd2;  // instruction held for decode
    localparam fetch_state_t DRAIN = 2'd3;  // stale request outstanding, response dropped

    localparam u64 DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Fixed-priority redirect arbiter: interrupt > leave > csrwrite > jump.
module redirect_arb
    import fetch_ctrl_pkg::*;
(
    input  u1  interrupt,
    input  u64 interrupt_pc,
    input  u1  leave,
    input  u64 leave_pc,
    input  u1  csrwrite,
    input  u64 csrwrite_pc,
    input  u1  jump,
    input  u64 j_addr,
    output u1  any_redir,
    output u64 target
);

    assign any_redir = interrupt | leave | csrwrite | jump;

    // Only the highest-priority active source drives the target.
    always_comb begin
        target = j_addr;
        if (interrupt) begin
            target = interrupt_pc;
        end else if (leave) begin
            target = leave_pc;
        end else if (csrwrite) begin
            target = csrwrite_pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, drives the instruction-bus
// request, kills or drains in-flight fetches on redirect, and hands one
// instruction at a time to decode.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter u64          RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             interrupt,
    input  logic [63:0]      interrupt_pc,
    input  logic             leave,
    input  logic [63:0]      leave_pc,
    input  logic             csrwrite,
    input  logic [63:0]      csrwrite_pc,
    input  logic             jump,
    input  logic [63:0]      j_addr,
    output logic             ireq_valid,
    output logic [63:0]      ireq_addr,
    input  logic             iresp_ok,
    input  logic [31:0]      iresp_data,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [63:0]      if_pc,
    output logic [31:0]      if_instr,
    output logic [CNT_W-1:0] kill_cnt
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t     r_state;
    u64               r_pc_q;
    u32               r_instr_q;
    u64               r_pend_pc;
    logic [CNT_W-1:0] r_kill_cnt;

    fetch_state_t     w_state_d;
    u64               w_pc_d;
    u32               w_instr_d;
    u64               w_pend_d;
    logic [CNT_W-1:0] w_kill_d;
    u1                w_kill;
    u1                w_any_redir;
    u64               w_target;

    redirect_arb u_redirect_arb (
        .interrupt    (interrupt),
        .interrupt_pc (interrupt_pc),
        .leave        (leave),
        .leave_pc     (leave_pc),
        .csrwrite     (csrwrite),
        .csrwrite_pc  (csrwrite_pc),
        .jump         (jump),
        .j_addr       (j_addr),
        .any_redir    (w_any_redir),
        .target       (w_target)
    );

    // Next-state logic for the FSM, PC, held instruction and kill counter.
    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        w_pend_d  = r_pend_pc;
        w_kill    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_d = REQ;
            end
            REQ: begin
                if (iresp_ok) begin
                    if (w_any_redir) begin
                        // Response arrived alongside a redirect: drop it, refetch.
                        w_pc_d = w_target;
                        w_kill = 1'b1;
                    end else begin
                        w_instr_d = iresp_data;
                        w_state_d = HOLD;
                    end
                end else if (w_any_redir) begin
                    // Bus address must stay stable, so park the target.
                    w_pend_d  = w_target;
                    w_state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_any_redir) begin
                    w_pend_d = w_target;
                end
                if (iresp_ok) begin
                    w_kill    = 1'b1;
                    w_pc_d    = w_any_redir ? w_target : r_pend_pc;
                    w_state_d = REQ;
                end
            end
            HOLD: begin
                if (w_any_redir) begin
                    w_pc_d    = w_target;
                    w_kill    = 1'b1;
                    w_state_d = REQ;
                end else if (if_ready) begin
                    w_pc_d    = r_pc_q + 64'd4;
                    w_state_d = REQ;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        // Saturating counter.
        w_kill_d = (w_kill && !(&r_kill_cnt)) ? r_kill_cnt + CntOne : r_kill_cnt;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pc_q     <= RESET_PC;
            r_instr_q  <= 32'd0;
            r_pend_pc  <= 64'd0;
            r_kill_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_instr_q  <= w_instr_d;
            r_pend_pc  <= w_pend_d;
            r_kill_cnt <= w_kill_d;
        end
    end

    assign ireq_valid = (r_state == REQ) || (r_state == DRAIN);
    assign ireq_addr  = r_pc_q;
    // A same-cycle redirect hides the held instruction from decode.
    assign if_valid   = (r_state == HOLD) && !w_any_redir;
    assign if_pc      = r_pc_q;
    assign if_instr   = r_instr_q;
    assign kill_cnt   = r_kill_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

    localparam int unsigned CntW = 3;

    logic            clk;
    logic            reset;
    logic            interrupt;
    logic [63:0]     interrupt_pc;
    logic            leave;
    logic [63:0]     leave_pc;
    logic            csrwrite;
    logic [63:0]     csrwrite_pc;
    logic            jump;
    logic [63:0]     j_addr;
    logic            ireq_valid;
    logic [63:0]     ireq_addr;
    logic            iresp_ok;
    logic [31:0]     iresp_data;
    logic            if_valid;
    logic            if_ready;
    logic [63:0]     if_pc;
    logic [31:0]     if_instr;
    logic [CntW-1:0] kill_cnt;

    int n_tests;
    int n_fail;

    fetch_ctrl #(
        .RESET_PC (64'h0000_0000_8000_0000),
        .CNT_W    (CntW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .interrupt    (interrupt),
        .interrupt_pc (interrupt_pc),
        .leave        (leave),
        .leave_pc     (leave_pc),
        .csrwrite     (csrwrite),
        .csrwrite_pc  (csrwrite_pc),
        .jump         (jump),
        .j_addr       (j_addr),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_ok     (iresp_ok),
        .iresp_data   (iresp_data),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .kill_cnt     (kill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redir();
        interrupt = 1'b0;
        leave     = 1'b0;
        csrwrite  = 1'b0;
        jump      = 1'b0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b0;
        clear_redir();
        interrupt_pc = 64'd0;
        leave_pc     = 64'd0;
        csrwrite_pc  = 64'd0;
        j_addr       = 64'd0;
        iresp_ok     = 1'b0;
        iresp_data   = 32'd0;
        if_ready     = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_kill_cnt", 64'(kill_cnt), 64'd0);
        reset = 1'b1;
        #1;
        check("idle_ireq_valid", 64'(ireq_valid), 64'd0);
        cyc();

        // Back-to-back fetches, one-cycle bus response, decode always ready.
        for (int i = 0; i < 3; i++) begin
            check("seq_req_valid", 64'(ireq_valid), 64'd1);
            check("seq_req_addr", ireq_addr, 64'h8000_0000 + 64'(4 * i));
            check("seq_req_if_valid", 64'(if_valid), 64'd0);
            iresp_ok   = 1'b1;
            iresp_data = 32'h0000_0013;
            if_ready   = 1'b1;
            cyc();
            iresp_ok = 1'b0;
            #1;
            check("seq_hold_if_valid", 64'(if_valid), 64'd1);
            check("seq_hold_if_pc", if_pc, 64'h8000_0000 + 64'(4 * i));
            check("seq_hold_if_instr", 64'(if_instr), 64'h13);
            check("seq_hold_no_req", 64'(ireq_valid), 64'd0);
            cyc();
        end
        check("seq_kill_cnt", 64'(kill_cnt), 64'd0);

        // Decode stalls for 5 cycles in HOLD.
        check("stall_req_addr", ireq_addr, 64'h8000_000C);
        if_ready   = 1'b0;
        iresp_ok   = 1'b1;
        iresp_data = 32'hDEAD_BEEF;
        cyc();
        iresp_ok = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("stall_if_valid", 64'(if_valid), 64'd1);
            check("stall_if_pc", if_pc, 64'h8000_000C);
            check("stall_if_instr", 64'(if_instr), 64'hDEAD_BEEF);
            check("stall_no_req", 64'(ireq_valid), 64'd0);
            cyc();
        end
        if_ready = 1'b1;
        cyc();
        check("stall_next_addr", ireq_addr, 64'h8000_0010);

        // Jump while request outstanding: drain, then refetch at target.
        jump   = 1'b1;
        j_addr = 64'h8000_1000;
        cyc();
        jump = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("drain_req_valid", 64'(ireq_valid), 64'd1);
            check("drain_req_addr", ireq_addr, 64'h8000_0010);
            if (k == 2) begin
                iresp_ok   = 1'b1;
                iresp_data = 32'hBAD0_BAD0;
            end
            cyc();
        end
        iresp_ok = 1'b0;
        #1;
        check("drain_new_addr", ireq_addr, 64'h8000_1000);
        check("drain_kill_cnt", 64'(kill_cnt), 64'd1);
        check("drain_no_if_valid", 64'(if_valid), 64'd0);

        // Simultaneous redirects in HOLD with decode ready: interrupt wins.
        iresp_ok   = 1'b1;
        iresp_data = 32'h0000_0013;
        cyc();
        iresp_ok     = 1'b0;
        interrupt    = 1'b1;
        interrupt_pc = 64'h8000_0100;
        leave        = 1'b1;
        leave_pc     = 64'h8000_0200;
        jump         = 1'b1;
        j_addr       = 64'h8000_1234;
        if_ready     = 1'b1;
        #1;
        check("prio_if_valid_killed", 64'(if_valid), 64'd0);
        cyc();
        clear_redir();
        #1;
        check("prio_req_addr", ireq_addr, 64'h8000_0100);
        check("prio_req_valid", 64'(ireq_valid), 64'd1);
        check("prio_kill_cnt", 64'(kill_cnt), 64'd2);

        // Response and redirect in the same REQ cycle: refetch immediately.
        iresp_ok    = 1'b1;
        csrwrite    = 1'b1;
        csrwrite_pc = 64'h8000_0400;
        cyc();
        clear_redir();
        iresp_ok = 1'b0;
        #1;
        check("okredir_req_addr", ireq_addr, 64'h8000_0400);
        check("okredir_if_valid", 64'(if_valid), 64'd0);
        check("okredir_kill_cnt", 64'(kill_cnt), 64'd3);

        // In DRAIN the latest redirect wins.
        jump   = 1'b1;
        j_addr = 64'h8000_2000;
        cyc();
        jump = 1'b0;
        #1;
        check("latest_drain_addr", ireq_addr, 64'h8000_0400);
        cyc();
        csrwrite    = 1'b1;
        csrwrite_pc = 64'h8000_3000;
        cyc();
        csrwrite = 1'b0;
        iresp_ok = 1'b1;
        #1;
        check("latest_drain_addr2", ireq_addr, 64'h8000_0400);
        cyc();
        iresp_ok = 1'b0;
        #1;
        check("latest_req_addr", ireq_addr, 64'h8000_3000);
        check("latest_kill_cnt", 64'(kill_cnt), 64'd4);

        // Redirect coincident with the draining response takes the live target.
        leave    = 1'b1;
        leave_pc = 64'h8000_5000;
        cyc();
        leave    = 1'b0;
        iresp_ok = 1'b1;
        jump     = 1'b1;
        j_addr   = 64'h0000_0000_8800_0000;
        cyc();
        clear_redir();
        iresp_ok = 1'b0;
        #1;
        check("drainredir_req_addr", ireq_addr, 64'h0000_0000_8800_0000);
        check("drainredir_kill_cnt", 64'(kill_cnt), 64'd5);

        // PC increment wraps at 2^64.
        iresp_ok = 1'b1;
        jump     = 1'b1;
        j_addr   = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        clear_redir();
        iresp_ok = 1'b0;
        #1;
        check("wrap_req_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_kill_cnt", 64'(kill_cnt), 64'd6);
        iresp_ok   = 1'b1;
        iresp_data = 32'h0010_0073;
        if_ready   = 1'b1;
        cyc();
        iresp_ok = 1'b0;
        #1;
        check("wrap_if_valid", 64'(if_valid), 64'd1);
        check("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        check("wrap_next_addr", ireq_addr, 64'd0);
        check("wrap_next_valid", 64'(ireq_valid), 64'd1);

        // Kill counter saturates at all-ones.
        iresp_ok = 1'b1;
        jump     = 1'b1;
        j_addr   = 64'h100;
        cyc();
        check("sat_kill_cnt7", 64'(kill_cnt), 64'd7);
        check("sat_addr1", ireq_addr, 64'h100);
        j_addr = 64'h200;
        cyc();
        clear_redir();
        iresp_ok = 1'b0;
        #1;
        check("sat_kill_hold", 64'(kill_cnt), 64'd7);
        check("sat_addr2", ireq_addr, 64'h200);

        // Reset asserted while draining.
        jump   = 1'b1;
        j_addr = 64'h8000_9000;
        cyc();
        jump = 1'b0;
        #1;
        check("rstd_drain_valid", 64'(ireq_valid), 64'd1);
        iresp_ok = 1'b1;
        reset    = 1'b0;
        #1;
        check("rstd_ireq_valid", 64'(ireq_valid), 64'd0);
        check("rstd_kill_cnt", 64'(kill_cnt), 64'd0);
        check("rstd_if_valid", 64'(if_valid), 64'd0);
        cyc();
        iresp_ok = 1'b0;
        reset    = 1'b1;
        #1;
        check("rstd_idle_valid", 64'(ireq_valid), 64'd0);
        cyc();
        check("rstd_first_valid", 64'(ireq_valid), 64'd1);
        check("rstd_first_addr", ireq_addr, 64'h8000_0000);
        check("rstd_first_kill", 64'(kill_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
